// File: rtl/aes_pkg.sv
// Shared AES-128 helpers for the wide sequential encryptor: S-box, MixColumns,
// round constants, FSM state encodings and the round count.
package aes_pkg;

  localparam logic [3:0] AES_NR = 4'd10;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [7:0] AES_RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Entry b of the forward S-box lives at bits [8*b +: 8] (ascending order).
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*int'(b) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_wide_encrypt_seq_if.sv
// Valid/ready bus of the wide AES encryptor; W is the full block width.
interface aes_wide_encrypt_seq_if #(parameter int W = 512);

  logic         in_valid;
  logic         in_ready;
  logic [0:W-1] data;
  logic [0:W-1] cipher_key;
  logic         out_valid;
  logic         out_ready;
  logic [0:W-1] encrypted_data;
  logic         busy;

  modport master (
    output in_valid, data, cipher_key, out_ready,
    input  in_ready, out_valid, encrypted_data, busy
  );

  modport slave (
    input  in_valid, data, cipher_key, out_ready,
    output in_ready, out_valid, encrypted_data, busy
  );

endinterface

// File: rtl/aes128_round_lane.sv
// One AES-128 lane: state and round-key registers, one full round per step
// with the next round key expanded on the fly.
module aes128_round_lane
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic         i_last,
  input  logic [7:0]   i_rcon,
  input  logic [0:127] i_state,
  input  logic [0:127] i_key,
  output logic [0:127] o_state
);

  logic [0:127] r_state;
  logic [0:127] r_key;
  logic [0:127] w_sr;
  logic [0:127] w_mc;
  logic [0:127] w_next_key;
  logic [31:0]  w_temp;
  logic [31:0]  w_nk0, w_nk1, w_nk2, w_nk3;

  // SubBytes + ShiftRows: row r of column c comes from column (c+r)%4.
  always_comb begin
    w_sr = '0;
    w_mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[8*(4*c+r) +: 8] = sbox(r_state[8*(4*((c+r)%4)+r) +: 8]);
      end
      w_mc[32*c +: 32] = mix_column(w_sr[32*c +: 32]);
    end
  end

  always_comb begin
    w_temp = {sbox(r_key[104 +: 8]), sbox(r_key[112 +: 8]),
              sbox(r_key[120 +: 8]), sbox(r_key[96 +: 8])} ^ {i_rcon, 24'h000000};
    w_nk0 = r_key[0  +: 32] ^ w_temp;
    w_nk1 = r_key[32 +: 32] ^ w_nk0;
    w_nk2 = r_key[64 +: 32] ^ w_nk1;
    w_nk3 = r_key[96 +: 32] ^ w_nk2;
    w_next_key = {w_nk0, w_nk1, w_nk2, w_nk3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_key   <= '0;
    end else if (i_load) begin
      r_state <= i_state ^ i_key;
      r_key   <= i_key;
    end else if (i_step) begin
      r_state <= (i_last ? w_sr : w_mc) ^ w_next_key;
      r_key   <= w_next_key;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/aes_wide_encrypt_seq.sv
// NLANES-wide sequential AES-128 encryptor with valid/ready handshakes.
// Optional macro AES_WIDE_OUT_INTERLEAVE_EN re-interleaves the ciphertext bytes.
module aes_wide_encrypt_seq
  import aes_pkg::*;
#(
  parameter int NLANES     = 4,
  parameter bit SHARED_KEY = 1'b0
) (
  input logic clk,
  input logic rst,
  aes_wide_encrypt_seq_if.slave bus
);

  localparam int W = NLANES * 128;

  state_t       r_fsm;
  logic [3:0]   r_round_cnt;
  logic         w_accept;
  logic         w_last;
  logic [7:0]   w_rcon;
  logic [0:W-1] w_result;

  assign w_accept = (r_fsm == IDLE) && bus.in_valid;
  assign w_last   = (r_round_cnt == AES_NR);
  assign w_rcon   = (r_round_cnt >= 4'd1 && r_round_cnt <= AES_NR) ?
                    AES_RCON[r_round_cnt - 4'd1] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_round_cnt <= 4'd0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (bus.in_valid) begin
            r_fsm       <= BUSY;
            r_round_cnt <= 4'd1;
          end
        end
        BUSY: begin
          if (w_last) begin
            r_fsm       <= DONE;
            r_round_cnt <= 4'd0;
          end else begin
            r_round_cnt <= r_round_cnt + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) r_fsm <= IDLE;
        end
        default: begin
          r_fsm       <= IDLE;
          r_round_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Byte j of the block feeds lane j%NLANES at byte position j/NLANES.
  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    logic [0:127] w_lane_in;
    logic [0:127] w_lane_key;
    logic [0:127] w_lane_out;

    for (genvar p = 0; p < 16; p++) begin : g_in_byte
      assign w_lane_in[8*p +: 8] = bus.data[8*(p*NLANES+k) +: 8];
    end

    if (SHARED_KEY) begin : g_shared_key
      assign w_lane_key = bus.cipher_key[0:127];
    end else begin : g_own_key
      assign w_lane_key = bus.cipher_key[128*k +: 128];
    end

    aes128_round_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept),
      .i_step  (r_fsm == BUSY),
      .i_last  (w_last),
      .i_rcon  (w_rcon),
      .i_state (w_lane_in),
      .i_key   (w_lane_key),
      .o_state (w_lane_out)
    );

`ifdef AES_WIDE_OUT_INTERLEAVE_EN
    for (genvar p = 0; p < 16; p++) begin : g_out_byte
      assign w_result[8*(p*NLANES+k) +: 8] = w_lane_out[8*p +: 8];
    end
`else
    assign w_result[128*k +: 128] = w_lane_out;
`endif
  end

  // Intermediate round states never reach the output; it reads zero outside DONE.
  assign bus.encrypted_data = (r_fsm == DONE) ? w_result : '0;
  assign bus.in_ready       = (r_fsm == IDLE);
  assign bus.out_valid      = (r_fsm == DONE);
  assign bus.busy           = (r_fsm == BUSY);

endmodule

// File: doc/aes_wide_encrypt_seq.md
Name: aes_wide_encrypt_seq

Overview:
Parametrised, sequential successor to the team's fixed 4-lane 512-bit AES-128 encryptor. Splits an NLANES*128-bit block into NLANES byte-interleaved 128-bit lanes and encrypts all lanes in parallel with iterative round-per-cycle AES-128 cores. Uses a valid/ready handshake on both input and output. Sits between the wide data source and the ciphertext sink, and replaces the purely combinational wide encryptor where timing requires it.

Parameters:
NLANES, 4, number of 128-bit AES lanes (>=1); block width W = NLANES*128
SHARED_KEY, 0, 0 = each lane uses its own 128-bit key slice; 1 = cipher_key[0:127] is broadcast to all lanes and the remaining key bits are ignored

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  data/cipher_key valid
in_ready  output  1  block can accept a new input
data  input  W  plaintext, MSB-first bit order [0:W-1]
cipher_key  input  W  lane keys; lane k uses bits [k*128 +: 128]
out_valid  output  1  encrypted_data valid
out_ready  input  1  sink accepts the output
encrypted_data  output  W  ciphertext
busy  output  1  rounds are in progress

Behaviour:
- Reset values: in_ready=1 on the first cycle after reset; out_valid=0, busy=0, encrypted_data=0. State is IDLE.
- De-interleave: byte j of data (bits [8j +: 8]) goes to lane j%NLANES, byte position j/NLANES.
- Output order: encrypted_data is the concatenation of the lane results, lane 0 first. There is no re-interleave unless the optional feature is enabled.
- FSM:
  - IDLE: in_ready=1. An accept (in_valid && in_ready) captures the de-interleaved state XOR round-0 key into each lane and captures the lane keys. Sets round_cnt=1 and moves to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle every lane applies SubBytes, ShiftRows, MixColumns and AddRoundKey. The round key is expanded on the fly using rcon[round_cnt]. Round 10 omits MixColumns. After round 10 the block moves to DONE.
  - DONE: out_valid=1 and encrypted_data is held stable until out_ready. On out_valid && out_ready the block returns to IDLE and out_valid falls in the next cycle.
- Latency: accept at edge T gives out_valid=1 from edge T+10. Minimum period is 11 cycles per block when out_ready is held at 1.
- No overlap: in_ready=0 in BUSY and DONE. Input changes after the accept are ignored.
- out_ready asserted while out_valid=0 has no effect.
- NLANES=1 degenerates to a single sequential AES-128.
- rst asserted in any state aborts the operation on the next edge: all values return to reset values and no partial output is produced.
- All lanes share one FSM and one round counter. The lanes are always in lockstep.

Optional Feature:
AES_WIDE_OUT_INTERLEAVE_EN
- Defined: the ciphertext is re-interleaved with the inverse of the input mapping. Lane k byte i is output as byte i*NLANES+k.
- Undefined: lane-concatenated output as above.
- Latency and handshake are identical in both cases.

Decomposition:
- Package aes_pkg holds:
  - the sbox table function
  - xtime and the MixColumns column function
  - the rcon array (10 entries)
  - the FSM state typedef (IDLE/BUSY/DONE)
  - the constant AES_NR=10
- Sub-module aes128_round_lane: one lane's 128-bit state and round-key registers. Has load/step/last-round controls and is instantiated NLANES times. The top holds the FSM, the handshake and the (de)interleave wiring.

Test Plan:
- FIPS-197 App. B, NLANES=1: key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 -> encrypted_data 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 cycles after the accept.
- NLANES=4, SHARED_KEY=1: key 000102030405060708090a0b0c0d0e0f; data with each plaintext byte of 00112233445566778899aabbccddeeff repeated 4x (00000000 11111111 ...) -> four concatenated copies of 69c4e0d86a7b0430d8cdb78070b4c55a. With AES_WIDE_OUT_INTERLEAVE_EN defined -> 69696969c4c4c4c4 ...
- NLANES=4, SHARED_KEY=0: lanes 0/2 use the App. B key/pt and lanes 1/3 use the App. C.1 key/pt -> each lane's slice matches its expected value.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> encrypted_data is stable, in_ready=0 and out_valid=1 throughout. The handshake completes on out_ready=1 and in_ready=1 follows one cycle later.
- Reset mid-run: rst asserted at round 5 -> next cycle out_valid=0, busy=0, in_ready=1 and encrypted_data=0. A fresh block then yields the correct ciphertext.
- Back-to-back: in_valid held 1 with out_ready=1 -> blocks are accepted every 11 cycles. An input change while busy does not alter the in-flight result.
